// File: rtl/stack_machine_memory.sv
// Unified program/data memory for the stack machine core.
// One single-ported array is shared by a read-only fetch port and a
// read/write data port. The data port has fixed priority over fetch.
// After reset the array is swept to zero, and programs can be loaded
// serially at run time through the load interface.
module stack_machine_memory #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic              load_valid,
  input  logic [WIDTH-1:0]  load_data,
  output logic              load_done,
  output logic              busy,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [WIDTH-1:0]  if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [WIDTH-1:0]  d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [WIDTH-1:0]  d_rdata,
  output logic              d_err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  typedef enum logic [1:0] {ST_CLEAR, ST_RUN, ST_LOAD} state_t;

  state_t           state_reg, state_next;
  logic [PTR_W-1:0] ptr_reg;   // zero-sweep pointer
  logic [PTR_W-1:0] lptr_reg;  // program-load pointer

  logic [WIDTH-1:0] mem [DEPTH];

  logic             run_ok;
  logic             d_in_range, if_in_range;
  logic             mem_we;
  logic [PTR_W-1:0] mem_waddr;
  logic [WIDTH-1:0] mem_wdata;

  // Grants only in RUN, and not in the cycle that requests LOAD.
  assign run_ok      = (state_reg == ST_RUN) && !load_en;
  assign d_gnt       = run_ok && d_req;
  assign if_gnt      = run_ok && if_req && !d_req;
  // Gated with rst_n so every output reads 0 while reset is held.
  assign busy        = rst_n && (state_reg != ST_RUN);
  assign d_in_range  = int'(d_addr) < DEPTH;
  assign if_in_range = int'(if_addr) < DEPTH;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_CLEAR;
    else        state_reg <= state_next;
  end

  // Next-state logic: sweep, run, and serial load with early abort.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_CLEAR: if (ptr_reg == LAST) state_next = ST_RUN;
      ST_RUN:   if (load_en) state_next = ST_LOAD;
      ST_LOAD: begin
        if (load_valid && lptr_reg == LAST) state_next = ST_RUN;
        else if (!load_en)                  state_next = ST_RUN;
      end
      default:  state_next = ST_CLEAR;
    endcase
  end

  // Single write port: sweep, load, or granted in-range data write.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    case (state_reg)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = ptr_reg;
      end
      ST_LOAD: begin
        mem_we    = load_valid;
        mem_waddr = lptr_reg;
        mem_wdata = load_data;
      end
      ST_RUN: begin
        mem_we    = d_gnt && d_we && d_in_range;
        mem_waddr = d_addr[PTR_W-1:0];
        mem_wdata = d_wdata;
      end
      default: mem_we = 1'b0;
    endcase
  end

  // Array write; the array itself has no reset, the sweep clears it.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Sweep and load pointers; neither wraps past DEPTH-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg  <= '0;
      lptr_reg <= '0;
    end else begin
      if (state_reg == ST_CLEAR)
        ptr_reg <= (ptr_reg == LAST) ? '0 : ptr_reg + PTR_W'(1);
      if (state_reg == ST_LOAD) begin
        if (state_next != ST_LOAD) lptr_reg <= '0;
        else if (load_valid)       lptr_reg <= lptr_reg + PTR_W'(1);
      end
    end
  end

  // Registered read data, valid/err pulses and load completion pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_valid  <= 1'b0;
      if_rdata  <= '0;
      d_valid   <= 1'b0;
      d_rdata   <= '0;
      d_err     <= 1'b0;
      load_done <= 1'b0;
    end else begin
      if_valid  <= 1'b0;
      d_valid   <= 1'b0;
      d_err     <= 1'b0;
      load_done <= (state_reg == ST_LOAD) && load_valid && (lptr_reg == LAST);
      if (d_gnt) begin
        d_err <= !d_in_range;
        if (!d_we) begin
          d_valid <= 1'b1;
          d_rdata <= d_in_range ? mem[d_addr[PTR_W-1:0]] : '0;
        end
      end
      if (if_gnt) begin
        if_valid <= 1'b1;
        if_rdata <= if_in_range ? mem[if_addr[PTR_W-1:0]] : '0;
      end
    end
  end

endmodule

// File: tb/tb_stack_machine_memory.sv
// Scoreboard bench for stack_machine_memory: drivers push expected
// responses with their due cycle, a negedge monitor pops and compares.
module tb_stack_machine_memory;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_en, load_valid, load_done, busy;
  logic [7:0] load_data;
  logic       if_req, if_gnt, if_valid;
  logic [7:0] if_addr, if_rdata;
  logic       d_req, d_we, d_gnt, d_valid, d_err;
  logic [7:0] d_addr, d_wdata, d_rdata;

  stack_machine_memory dut (
    .clk(clk), .rst_n(rst_n),
    .load_en(load_en), .load_valid(load_valid), .load_data(load_data),
    .load_done(load_done), .busy(busy),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_valid(if_valid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata), .d_err(d_err)
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic [7:0] addr; logic [7:0] data; } if_exp_t;
  typedef struct { int due; logic [7:0] addr; logic valid; logic err; logic [7:0] data; } d_exp_t;

  if_exp_t    if_q[$];
  d_exp_t     d_q[$];
  if_exp_t    if_e;
  d_exp_t     d_e;
  logic [7:0] mdl [32];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: pops one expectation per presented response.
  always @(negedge clk) begin
    if (rst_n) begin
      if (load_done) done_cnt++;
      if (if_valid) begin
        if (if_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL if_unexpected: if_valid=1 rdata=0x%02h, required no response", if_rdata);
        end else begin
          if_e = if_q.pop_front();
          $display("fetch addr=%0d rdata=0x%02h (cycle %0d)", if_e.addr, if_rdata, cyc);
          chk("if_latency", cyc, if_e.due);
          chk("if_rdata", if_rdata, if_e.data);
        end
      end else if (if_q.size() > 0 && if_q[0].due <= cyc) begin
        n_checks++; n_fail++;
        $display("FAIL if_missing: if_valid=0 at cycle %0d, required 1", cyc);
        void'(if_q.pop_front());
      end
      if (d_valid || d_err) begin
        if (d_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL d_unexpected: valid=%0b err=%0b, required no response", d_valid, d_err);
        end else begin
          d_e = d_q.pop_front();
          $display("data  addr=%0d valid=%0b err=%0b rdata=0x%02h (cycle %0d)",
                   d_e.addr, d_valid, d_err, d_rdata, cyc);
          chk("d_latency", cyc, d_e.due);
          chk("d_valid", d_valid, d_e.valid);
          chk("d_err", d_err, d_e.err);
          if (d_e.valid) chk("d_rdata", d_rdata, d_e.data);
        end
      end else if (d_q.size() > 0 && d_q[0].due <= cyc) begin
        n_checks++; n_fail++;
        $display("FAIL d_missing: no response at cycle %0d, required one", cyc);
        void'(d_q.pop_front());
      end
    end
  end

  task automatic idle();
    if_req = 0; d_req = 0; d_we = 0; load_en = 0; load_valid = 0;
  endtask

  task automatic fetch(input logic [7:0] a, input string tag);
    @(negedge clk);
    idle();
    if_req = 1; if_addr = a;
    #1;
    chk({tag, "_if_gnt"}, if_gnt, 1);
    if (if_gnt) if_q.push_back('{cyc + 1, a, (a < 32) ? mdl[a[4:0]] : 8'h00});
  endtask

  task automatic dacc(input logic we, input logic [7:0] a, input logic [7:0] wd, input string tag);
    @(negedge clk);
    idle();
    d_req = 1; d_we = we; d_addr = a; d_wdata = wd;
    #1;
    chk({tag, "_d_gnt"}, d_gnt, 1);
    if (d_gnt) d_q.push_back('{cyc + 1, a, !we, a >= 32, (!we && a < 32) ? mdl[a[4:0]] : 8'h00});
    if (we && a < 32) mdl[a[4:0]] = wd;
  endtask

  task automatic fetch_all(input string tag);
    for (int a = 0; a < 32; a++) fetch(8'(a), tag);
    @(negedge clk);
    idle();
  endtask

  // Called at the release edge; counts cycles with busy high.
  task automatic wait_clear(input string tag);
    int cnt;
    #1;
    cnt = 0;
    while (busy && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    chk(tag, cnt, 32);
    for (int i = 0; i < 32; i++) mdl[i] = 8'h00;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 0; load_data = 0; if_addr = 0; d_addr = 0; d_wdata = 0;
    idle();
    // Reset state
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_d_valid", d_valid, 0);
    chk("rst_d_err", d_err, 0);
    chk("rst_load_done", load_done, 0);

    // 1. Sweep then all words read zero
    @(negedge clk);
    rst_n = 1;
    wait_clear("clear_cycles");
    fetch_all("t1");

    // 2. Full program load
    @(negedge clk);
    load_en = 1;
    @(negedge clk);
    #1;
    chk("load_busy", busy, 1);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (i == 31) chk("load_done_early", done_cnt, 0);
      load_valid = 1;
      load_data  = 8'(8'h0D - 3 * i);
      mdl[i]     = load_data;
    end
    @(negedge clk);
    load_valid = 0; load_en = 0;
    #1;
    chk("load_done_pulse", load_done, 1);
    chk("load_done_run", busy, 0);
    fetch(8'd1, "t2a");
    fetch(8'd0, "t2b");
    fetch(8'd31, "t2c");
    @(negedge clk);
    idle();
    chk("load_done_count", done_cnt, 1);

    // 3. Data port priority, read-after-write through the fetch port
    @(negedge clk);
    if_req = 1; if_addr = 8'd3;
    d_req = 1; d_we = 1; d_addr = 8'd3; d_wdata = 8'h55;
    #1;
    chk("prio_d_gnt", d_gnt, 1);
    chk("prio_if_gnt", if_gnt, 0);
    mdl[3] = 8'h55;
    fetch(8'd3, "t3");
    @(negedge clk);
    idle();

    // 4. Out-of-range accesses
    dacc(0, 8'd200, 8'h00, "t4r");
    dacc(1, 8'd40, 8'hAA, "t4w");
    dacc(0, 8'd8, 8'h00, "t4chk");
    fetch(8'd8, "t4f");
    fetch(8'd250, "t4oor");
    dacc(0, 8'd3, 8'h00, "t4rd3");
    @(negedge clk);
    idle();

    // 5. Load aborted after 5 words
    @(negedge clk);
    load_en = 1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      load_valid = 1;
      load_data  = 8'(8'hC0 + i);
      mdl[i]     = load_data;
    end
    @(negedge clk);
    load_valid = 0; load_en = 0;
    @(negedge clk);
    #1;
    chk("abort_run", busy, 0);
    chk("abort_no_done", done_cnt, 1);
    fetch_all("t5");

    // 6. Reset in the middle of a load
    @(negedge clk);
    load_en = 1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      load_valid = 1; load_data = 8'hEE;
    end
    @(negedge clk);
    load_valid = 0;
    #1;
    chk("midload_busy", busy, 1);
    #1;
    rst_n = 0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_if_valid", if_valid, 0);
    chk("midrst_d_valid", d_valid, 0);
    chk("midrst_load_done", load_done, 0);
    idle();
    @(negedge clk);
    rst_n = 1;
    wait_clear("reclear_cycles");
    fetch_all("t6");

    repeat (3) @(negedge clk);
    chk("if_q_drained", if_q.size(), 0);
    chk("d_q_drained", d_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
